// File: rtl/ntt_bank_array.sv
// Multi-bank simple dual-port coefficient store for the NTT datapath.
// Per-bank write/read ports, optional output stage, zero-clear sequencer.
module ntt_bank_array #(
    parameter int DW      = 14,
    parameter int DEPTH   = 128,
    parameter int AW      = 7,
    parameter int NB      = 4,
    parameter int RD_PIPE = 0,
    parameter int RW_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ien,
    input  logic [NB-1:0]    wen,
    input  logic [NB*AW-1:0] wa,
    input  logic [NB*DW-1:0] wd,
    input  logic [NB-1:0]    ren,
    input  logic [NB*AW-1:0] ra,
    output logic [NB*DW-1:0] rd,
    output logic [NB-1:0]    rvalid,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_e;

    // One bit wider than the address so the last-word compare never wraps
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    state_e      state_q;
    logic [AW:0] cnt_q;
    logic        busy_q;
    logic        done_q;

    assign clr_busy = busy_q;
    assign clr_done = done_q;

    // Clear sequencer: sweeps every address of all banks, then pulses done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (clr_start) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic          we;
        logic [AW-1:0] waddr;
        logic [AW-1:0] raddr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdat_d;
        logic [DW-1:0] rdat_q;
        logic          rv_q;

        // The sequencer takes the write port outright; user writes drop
        assign we    = busy_q | (ien & wen[b]);
        assign waddr = busy_q ? cnt_q[AW-1:0] : wa[b*AW +: AW];
        assign wdata = busy_q ? '0 : wd[b*DW +: DW];
        assign raddr = ra[b*AW +: AW];

        // Read mux: old word, or the word being written when forwarding
        always_comb begin
            rdat_d = mem[raddr];
            if (RW_MODE == 1 && we && waddr == raddr) begin
                rdat_d = wdata;
            end
        end

        // RAM array write port, no reset on contents
        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
        end

        // RAM read register; frozen entirely while ien is low
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdat_q <= '0;
                rv_q   <= 1'b0;
            end else if (ien) begin
                rv_q <= ren[b];
                if (ren[b]) begin
                    rdat_q <= rdat_d;
                end
            end
        end

        if (RD_PIPE == 1) begin : g_pipe
            logic [DW-1:0] p_q;
            logic          pv_q;

            // Extra output stage, frozen with the rest of the read path
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_q  <= '0;
                    pv_q <= 1'b0;
                end else if (ien) begin
                    p_q  <= rdat_q;
                    pv_q <= rv_q;
                end
            end

            assign rd[b*DW +: DW] = p_q;
            assign rvalid[b]      = pv_q;
        end else begin : g_nopipe
            assign rd[b*DW +: DW] = rdat_q;
            assign rvalid[b]      = rv_q;
        end
    end

endmodule

// File: tb/tb_ntt_bank_array.sv
// Bench for ntt_bank_array: two instances (read-old/no pipe and
// forward/one pipe stage) driven in parallel against a behavioural model.
module tb_ntt_bank_array;

    localparam int DW    = 14;
    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int NB    = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             ien       = 1'b0;
    logic             clr_start = 1'b0;
    logic [NB-1:0]    wen       = '0;
    logic [NB-1:0]    ren       = '0;
    logic [NB*AW-1:0] wa        = '0;
    logic [NB*AW-1:0] ra        = '0;
    logic [NB*DW-1:0] wd        = '0;

    logic [NB*DW-1:0] rd0, rd1;
    logic [NB-1:0]    rv0, rv1;
    logic             busy0, busy1, done0, done1;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model state
    int mem_m [NB][DEPTH];
    int e0_rd [NB];
    int e1_rd [NB];
    int s1_rd [NB];
    bit e0_rv [NB];
    bit e1_rv [NB];
    bit s1_rv [NB];
    bit m_busy;
    bit m_done;
    int m_cnt;

    always #5 clk = ~clk;

    ntt_bank_array #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NB(NB),
        .RD_PIPE(0), .RW_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ien(ien),
        .wen(wen), .wa(wa), .wd(wd),
        .ren(ren), .ra(ra), .rd(rd0), .rvalid(rv0),
        .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0)
    );

    ntt_bank_array #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NB(NB),
        .RD_PIPE(1), .RW_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ien(ien),
        .wen(wen), .wa(wa), .wd(wd),
        .ren(ren), .ra(ra), .rd(rd1), .rvalid(rv1),
        .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1)
    );

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            e0_rd[b] = 0; e1_rd[b] = 0; s1_rd[b] = 0;
            e0_rv[b] = 0; e1_rv[b] = 0; s1_rv[b] = 0;
        end
        m_busy = 0;
        m_done = 0;
        m_cnt  = 0;
    endtask

    // Advance the model by one rising edge using the current inputs
    task automatic model_step();
        bit we [NB];
        int wad [NB];
        int wv [NB];
        int rad;
        int old;
        for (int b = 0; b < NB; b++) begin
            if (m_busy) begin
                we[b] = 1; wad[b] = m_cnt; wv[b] = 0;
            end else begin
                we[b]  = ien && wen[b];
                wad[b] = int'(wa[b*AW +: AW]);
                wv[b]  = int'(wd[b*DW +: DW]);
            end
        end
        if (ien) begin
            for (int b = 0; b < NB; b++) begin
                e1_rd[b] = s1_rd[b];
                e1_rv[b] = s1_rv[b];
                if (ren[b]) begin
                    rad = int'(ra[b*AW +: AW]);
                    old = mem_m[b][rad];
                    e0_rd[b] = old;
                    e0_rv[b] = 1;
                    s1_rd[b] = (we[b] && wad[b] == rad) ? wv[b] : old;
                    s1_rv[b] = 1;
                end else begin
                    e0_rv[b] = 0;
                    s1_rv[b] = 0;
                end
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (we[b]) mem_m[b][wad[b]] = wv[b];
        end
        if (m_busy) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (clr_start) begin
            m_busy = 1;
            m_cnt  = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wen       = '0;
        ren       = '0;
        clr_start = 1'b0;
    endtask

    task automatic set_wr(input int b, input int a, input int d);
        wen[b]          = 1'b1;
        wa[b*AW +: AW]  = AW'(a);
        wd[b*DW +: DW]  = DW'(d);
    endtask

    task automatic set_ra(input int b, input int a);
        ra[b*AW +: AW] = AW'(a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (rd0 !== '0 || rv0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            nerr++;
            $display("FAIL reset p0: rd=%h rv=%b busy=%b done=%b want zeros",
                     rd0, rv0, busy0, done0);
        end
        nvec++;
        if (rd1 !== '0 || rv1 !== '0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            nerr++;
            $display("FAIL reset p1: rd=%h rv=%b busy=%b done=%b want zeros",
                     rd1, rv1, busy1, done1);
        end
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        int busy_cycles;
        set_idle();
        ien       = 1'b1;
        clr_start = 1'b1;
        tick();
        set_idle();
        busy_cycles = 0;
        for (int i = 0; i < 300 && busy0 === 1'b1; i++) begin
            tick();
            busy_cycles++;
        end
        nvec++;
        if (busy_cycles != DEPTH) begin
            nerr++;
            $display("FAIL clear_len: busy %0d cycles want %0d", busy_cycles, DEPTH);
        end
        nvec++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || m_done !== 1'b1) begin
            nerr++;
            $display("FAIL clear_done: got %b/%b want 1", done0, done1);
        end
        tick();
        nvec++;
        if (done0 !== 1'b0 || done1 !== 1'b0) begin
            nerr++;
            $display("FAIL clear_done_end: got %b/%b want 0", done0, done1);
        end
        for (int a = 0; a <= DEPTH; a++) begin
            set_idle();
            if (a < DEPTH) begin
                ren = '1;
                for (int b = 0; b < NB; b++) set_ra(b, a);
            end
            tick();
            for (int b = 0; b < NB; b++) begin
                nvec++;
                if (rd0[b*DW +: DW] !== DW'(e0_rd[b]) || rv0[b] !== e0_rv[b]
                    || e0_rd[b] != 0) begin
                    nerr++;
                    $display("FAIL clear_read p0 a%0d lane%0d: got %h/%b want %h/%b",
                             a, b, rd0[b*DW +: DW], rv0[b], e0_rd[b], e0_rv[b]);
                end
                nvec++;
                if (rd1[b*DW +: DW] !== DW'(e1_rd[b]) || rv1[b] !== e1_rv[b]) begin
                    nerr++;
                    $display("FAIL clear_read p1 a%0d lane%0d: got %h/%b want %h/%b",
                             a, b, rd1[b*DW +: DW], rv1[b], e1_rd[b], e1_rv[b]);
                end
            end
        end
    endtask

    task automatic test_parallel();
        set_idle();
        set_wr(0, 5, 'h1A2B);
        set_wr(3, 127, 'h3FFF);
        tick();
        set_idle();
        ren = 4'b1001;
        set_ra(0, 5);
        set_ra(3, 127);
        tick();
        nvec++;
        if (rd0[0 +: DW] !== 14'h1A2B || rd0[3*DW +: DW] !== 14'h3FFF
            || rv0 !== 4'b1001) begin
            nerr++;
            $display("FAIL par p0: rd=%h rv=%b want 1a2b/3fff rv=1001", rd0, rv0);
        end
        nvec++;
        if (rd0[DW +: DW] !== DW'(e0_rd[1]) || rd0[2*DW +: DW] !== DW'(e0_rd[2])) begin
            nerr++;
            $display("FAIL par hold p0: lanes1/2 %h/%h want %h/%h",
                     rd0[DW +: DW], rd0[2*DW +: DW], e0_rd[1], e0_rd[2]);
        end
        set_idle();
        tick();
        nvec++;
        if (rd1[0 +: DW] !== 14'h1A2B || rd1[3*DW +: DW] !== 14'h3FFF
            || rv1 !== 4'b1001) begin
            nerr++;
            $display("FAIL par p1: rd=%h rv=%b want 1a2b/3fff rv=1001", rd1, rv1);
        end
        nvec++;
        if (rv0 !== 4'b0000 || rd0[0 +: DW] !== 14'h1A2B) begin
            nerr++;
            $display("FAIL par idle p0: rd0=%h rv=%b want hold rv=0000", rd0[0 +: DW], rv0);
        end
    endtask

    task automatic test_collision();
        set_idle();
        set_wr(1, 9, 'h0011);
        tick();
        set_idle();
        set_wr(1, 9, 'h2222);
        ren[1] = 1'b1;
        set_ra(1, 9);
        tick();
        nvec++;
        if (rd0[DW +: DW] !== 14'h0011 || rv0[1] !== 1'b1) begin
            nerr++;
            $display("FAIL coll old p0: got %h/%b want 0011/1", rd0[DW +: DW], rv0[1]);
        end
        set_idle();
        ren[1] = 1'b1;
        tick();
        nvec++;
        if (rd1[DW +: DW] !== 14'h2222 || rv1[1] !== 1'b1) begin
            nerr++;
            $display("FAIL coll fwd p1: got %h/%b want 2222/1", rd1[DW +: DW], rv1[1]);
        end
        nvec++;
        if (rd0[DW +: DW] !== 14'h2222) begin
            nerr++;
            $display("FAIL coll after p0: got %h want 2222", rd0[DW +: DW]);
        end
        set_idle();
        tick();
        nvec++;
        if (rd1[DW +: DW] !== 14'h2222) begin
            nerr++;
            $display("FAIL coll after p1: got %h want 2222", rd1[DW +: DW]);
        end
    endtask

    task automatic test_ien_freeze();
        int fa [NB];
        set_idle();
        ren = '1;
        for (int b = 0; b < NB; b++) set_ra(b, $urandom_range(0, DEPTH-1));
        tick();
        ien = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wen = NB'($urandom);
            ren = NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                fa[b] = $urandom_range(0, DEPTH-1);
                wa[b*AW +: AW] = AW'(fa[b]);
                wd[b*DW +: DW] = DW'($urandom);
                set_ra(b, $urandom_range(0, DEPTH-1));
            end
            tick();
            nvec++;
            if (rv0 !== 4'b1111) begin
                nerr++;
                $display("FAIL freeze rv p0 c%0d: got %b want 1111", c, rv0);
            end
            for (int b = 0; b < NB; b++) begin
                nvec++;
                if (rd0[b*DW +: DW] !== DW'(e0_rd[b]) || rd1[b*DW +: DW] !== DW'(e1_rd[b])
                    || rv1[b] !== e1_rv[b]) begin
                    nerr++;
                    $display("FAIL freeze hold c%0d lane%0d: got %h/%h want %h/%h",
                             c, b, rd0[b*DW +: DW], rd1[b*DW +: DW], e0_rd[b], e1_rd[b]);
                end
            end
        end
        ien = 1'b1;
        set_idle();
        ren = '1;
        for (int b = 0; b < NB; b++) set_ra(b, fa[b]);
        for (int c = 0; c < 3; c++) begin
            tick();
            set_idle();
            for (int b = 0; b < NB; b++) begin
                nvec++;
                if (rd0[b*DW +: DW] !== DW'(e0_rd[b]) || rv0[b] !== e0_rv[b]
                    || rd1[b*DW +: DW] !== DW'(e1_rd[b]) || rv1[b] !== e1_rv[b]) begin
                    nerr++;
                    $display("FAIL resume c%0d lane%0d: got %h/%b %h/%b want %h/%b %h/%b",
                             c, b, rd0[b*DW +: DW], rv0[b], rd1[b*DW +: DW], rv1[b],
                             e0_rd[b], e0_rv[b], e1_rd[b], e1_rv[b]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            set_idle();
            ien = ($urandom_range(0, 7) != 0);
            wen = NB'($urandom);
            ren = NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                wa[b*AW +: AW] = AW'($urandom_range(0, 7) + (b[0] ? 120 : 0));
                set_ra(b, $urandom_range(0, 7) + (b[0] ? 120 : 0));
                wd[b*DW +: DW] = DW'($urandom);
            end
            tick();
            for (int b = 0; b < NB; b++) begin
                nvec++;
                if (rd0[b*DW +: DW] !== DW'(e0_rd[b]) || rv0[b] !== e0_rv[b]) begin
                    nerr++;
                    $display("FAIL rand p0 c%0d lane%0d: got %h/%b want %h/%b",
                             c, b, rd0[b*DW +: DW], rv0[b], e0_rd[b], e0_rv[b]);
                end
                nvec++;
                if (rd1[b*DW +: DW] !== DW'(e1_rd[b]) || rv1[b] !== e1_rv[b]) begin
                    nerr++;
                    $display("FAIL rand p1 c%0d lane%0d: got %h/%b want %h/%b",
                             c, b, rd1[b*DW +: DW], rv1[b], e1_rd[b], e1_rv[b]);
                end
            end
        end
        ien = 1'b1;
        set_idle();
    endtask

    task automatic test_clear_interaction();
        int busy_cycles;
        set_idle();
        ien = 1'b1;
        set_wr(2, 50, 'h0ABC);
        tick();
        set_idle();
        clr_start = 1'b1;
        tick();
        busy_cycles = 0;
        for (int i = 0; i < 300 && busy0 === 1'b1; i++) begin
            set_idle();
            ren = NB'($urandom);
            for (int b = 0; b < NB; b++) set_ra(b, $urandom_range(i, i + 1));
            if (i == 60) clr_start = 1'b1;
            if (i == 80) set_wr(2, 50, 'h1555);
            tick();
            busy_cycles++;
            nvec++;
            if (busy0 !== m_busy || busy1 !== m_busy
                || done0 !== m_done || done1 !== m_done) begin
                nerr++;
                $display("FAIL clr_fsm i%0d: busy %b/%b done %b/%b want %b/%b",
                         i, busy0, busy1, done0, done1, m_busy, m_done);
            end
            for (int b = 0; b < NB; b++) begin
                nvec++;
                if (rd0[b*DW +: DW] !== DW'(e0_rd[b]) || rv0[b] !== e0_rv[b]
                    || rd1[b*DW +: DW] !== DW'(e1_rd[b]) || rv1[b] !== e1_rv[b]) begin
                    nerr++;
                    $display("FAIL clr_read i%0d lane%0d: got %h/%b %h/%b want %h/%b %h/%b",
                             i, b, rd0[b*DW +: DW], rv0[b], rd1[b*DW +: DW], rv1[b],
                             e0_rd[b], e0_rv[b], e1_rd[b], e1_rv[b]);
                end
            end
        end
        nvec++;
        if (busy_cycles != DEPTH || done0 !== 1'b1) begin
            nerr++;
            $display("FAIL clr_restart: busy %0d cycles done=%b want %0d/1",
                     busy_cycles, done0, DEPTH);
        end
        set_idle();
        ren[2] = 1'b1;
        set_ra(2, 50);
        tick();
        set_idle();
        tick();
        nvec++;
        if (rd0[2*DW +: DW] !== 14'h0000 || rd1[2*DW +: DW] !== 14'h0000) begin
            nerr++;
            $display("FAIL clr_drop: bank2[50] got %h/%h want 0000",
                     rd0[2*DW +: DW], rd1[2*DW +: DW]);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit saw_done;
        set_idle();
        set_wr(0, 100, 'h1234);
        set_wr(1, 10, 'h0777);
        tick();
        set_idle();
        clr_start = 1'b1;
        tick();
        set_idle();
        repeat (60) tick();
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || rv0 !== '0 || rv1 !== '0) begin
            nerr++;
            $display("FAIL rst_mid: busy %b/%b done %b rv %b/%b want all 0",
                     busy0, busy1, done0, rv0, rv1);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 140; c++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1 || busy0 === 1'b1) saw_done = 1;
        end
        nvec++;
        if (saw_done) begin
            nerr++;
            $display("FAIL rst_mid_done: got done/busy activity want none");
        end
        ren = 4'b0011;
        set_ra(0, 100);
        set_ra(1, 10);
        tick();
        set_idle();
        nvec++;
        if (rd0[0 +: DW] !== 14'h1234 || rd0[DW +: DW] !== 14'h0000 || rv0 !== 4'b0011) begin
            nerr++;
            $display("FAIL rst_mid_mem p0: got %h/%h rv %b want 1234/0000 rv 0011",
                     rd0[0 +: DW], rd0[DW +: DW], rv0);
        end
        tick();
        nvec++;
        if (rd1[0 +: DW] !== 14'h1234 || rd1[DW +: DW] !== 14'h0000 || rv1 !== 4'b0011) begin
            nerr++;
            $display("FAIL rst_mid_mem p1: got %h/%h rv %b want 1234/0000 rv 0011",
                     rd1[0 +: DW], rd1[DW +: DW], rv1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clear();
        test_parallel();
        test_collision();
        test_ien_freeze();
        test_random();
        test_clear_interaction();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ntt_bank_array.md
Name: ntt_bank_array

Overview:
- Parametrised multi-bank coefficient store for the NTT datapath.
- NB independent simple dual-port banks, each with its own write port and read port, driven in parallel by the butterfly/address-generation logic.
- Adds features the single-bank store lacks: configurable width/depth/bank count, optional output pipeline with a valid flag, selectable read-during-write behaviour, and a built-in zero-clear sequencer.

Parameters:
- DW, 14, coefficient width in bits
- DEPTH, 128, words per bank; must be a power of two, minimum 2
- AW, 7, address width; must equal log2(DEPTH)
- NB, 4, number of banks
- RD_PIPE, 0, extra output register stages after the RAM read register; allowed values 0 or 1
- RW_MODE, 0, same-bank same-address read and write in one cycle: 0 = read-old, 1 = write-first (forward)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ien  input  1  global enable; 0 freezes user write and read paths
- wen  input  NB  per-bank write enable
- wa  input  NB*AW  per-bank write address; bank b uses bits [b*AW +: AW]
- wd  input  NB*DW  per-bank write data; bank b uses bits [b*DW +: DW]
- ren  input  NB  per-bank read enable
- ra  input  NB*AW  per-bank read address
- rd  output  NB*DW  per-bank read data (registered)
- rvalid  output  NB  per-bank read-data valid
- clr_start  input  1  one-cycle request to zero all banks
- clr_busy  output  1  high while the clear sequencer owns the write ports
- clr_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd, rvalid, clr_busy and clr_done go to 0 immediately.
  - Pipeline registers are cleared.
  - Sequencer goes to IDLE and its counter to 0.
  - RAM contents are not reset and are undefined after power-up.
- Writes (user):
  - At a rising edge with ien=1, clr_busy=0 and wen[b]=1, bank b address wa_b is written with wd_b.
  - Banks are fully independent; any combination of wen bits is legal.
- Reads:
  - At a rising edge with ien=1 and ren[b]=1, bank b captures the addressed word.
  - rd_b and rvalid[b]=1 appear 1+RD_PIPE cycles after the request edge.
  - ien=1 with ren[b]=0: rd_b holds its last value and rvalid[b] goes to 0 at the same latency.
  - ien=0: all read and pipeline registers, including rvalid, hold their values. The pipeline freezes; it does not drain.
- Same bank, same address, same edge, with both wen and ren active:
  - RW_MODE=0 returns the pre-write word.
  - RW_MODE=1 returns wd_b.
  - Different addresses never interact.
- Reads remain serviced during a clear.
  - Returned data equals the current RAM content.
  - A read of the address being cleared in that cycle follows RW_MODE, with forwarded data = 0.
- Clear sequencer FSM (runs regardless of ien):
  - IDLE: clr_busy=0. On clr_start=1, go to CLEAR with cnt=0.
  - CLEAR: clr_busy=1. Every cycle, write 0 to address cnt in all NB banks and increment cnt. After writing DEPTH-1 (DEPTH cycles total), go to DONE.
  - DONE: clr_busy=0 and clr_done=1 for exactly one cycle, then IDLE.
  - clr_start is ignored in CLEAR and DONE.
  - User wen is ignored (dropped, not queued) whenever clr_busy=1.
- Reset asserted mid-clear: FSM returns to IDLE and clr_done does not pulse. Banks are left partially cleared; software must reissue clr_start.
- The cnt width is AW+1 so the terminal comparison never wraps. Addresses are used modulo DEPTH only by construction, since wa and ra are AW bits wide.

Test Plan:
- Reset/init: hold rst_n=0 with clk running → rd=0, rvalid=0, clr_busy=0. Release, pulse clr_start → clr_busy=1 for 128 cycles, clr_done pulses on cycle 129. Afterwards, reading every address of all 4 banks returns 0.
- Parallel write/read, RD_PIPE=0 then 1:
  - Write bank0[5]=0x1A2B, bank3[127]=0x3FFF in one cycle.
  - Read both next cycle → values appear after 1 (respectively 2) cycles with rvalid=4'b1001.
  - Other rd lanes hold their prior values.
- Collision: bank1 holds 0x0011 at addr 9; same edge wen=ren=1 at addr 9 with wd=0x2222 → rd_1=0x0011 with RW_MODE=0, 0x2222 with RW_MODE=1. A subsequent read returns 0x2222 in both modes.
- ien freeze:
  - Issue a read, then drop ien for 3 cycles while toggling wen and ren → no RAM change, rd/rvalid hold.
  - Raise ien → pipeline resumes with the original data.
- Clear interaction:
  - User writes during CLEAR are dropped: bank2[50] is still 0 after clr_done.
  - clr_start pulsed mid-clear does not restart the counter: total busy time stays 128 cycles.
- Reset mid-clear: assert rst_n at cnt=60 → clr_busy=0 asynchronously, no clr_done. Address 10 reads 0; address 100 retains its earlier non-zero value.
